// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the multiport register bank and its clear sequencer.
package reg_bank_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_bank_clear_ctrl.sv
// Clear sequencer: walks the array one entry per cycle after reset or on request.
module reg_bank_clear_ctrl
    import reg_bank_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr_req,
    output logic          o_clr_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr,
    output clr_state_e    o_state
);

    localparam logic [AW-1:0] LP_LAST = AW'(DEPTH - 1);

    clr_state_e    r_state;
    clr_state_e    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A request arriving while clearing is ignored; the sweep never restarts early.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            CLEAR: begin
                w_cnt_nxt = r_cnt + AW'(1);
                if (r_cnt == LP_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            IDLE: begin
                if (i_clr_req) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_clr_busy = (r_state == CLEAR);
    assign o_clr_we   = (r_state == CLEAR);
    assign o_clr_addr = r_cnt;
    assign o_state    = r_state;

endmodule

// File: rtl/reg_bank_multiport.sv
// Parametrised register bank: NRD registered read ports, one write port with
// optional write-first bypass, optional hardwired-zero r0 and a hardware clear.
module reg_bank_multiport
    import reg_bank_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NRD*AW-1:0]      rd_addr,
    output logic [NRD*WIDTH-1:0]   rd_data,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   clr_req,
    output logic                   clr_busy
);

    localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_port_we;
    logic             w_clr_we;
    logic [AW-1:0]    w_clr_addr;
    clr_state_e       w_state;

    reg_bank_clear_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_ctrl (
        .clk        (clk),
        .rst        (rst),
        .i_clr_req  (clr_req),
        .o_clr_busy (clr_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_state    (w_state)
    );

    // Port writes only land while idle; out-of-range and protected r0 writes vanish.
    assign w_port_we = wr_en && (w_state == IDLE) && ({1'b0, wr_addr} < LP_DEPTH)
                       && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_port_we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]    w_addr;
        logic [WIDTH-1:0] w_val;
        logic [WIDTH-1:0] r_rd;

        assign w_addr = rd_addr[g*AW +: AW];

        always_comb begin
            w_val = r_mem[w_addr];
            if ((w_state == CLEAR) || ({1'b0, w_addr} >= LP_DEPTH)
                || ((ZERO_REG != 0) && (w_addr == '0))) begin
                w_val = '0;
            end else if ((BYPASS != 0) && w_port_we && (wr_addr == w_addr)) begin
                w_val = wr_data;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd <= '0;
            end else begin
                r_rd <= w_val;
            end
        end

        assign rd_data[g*WIDTH +: WIDTH] = r_rd;
    end

endmodule

// File: tb/tb_reg_bank_multiport.sv
// Directed bench for reg_bank_multiport: default, read-old/no-zero and a 3-port 24x16 instance.
module tb_reg_bank_multiport;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // shared stimulus for the default and the alternate (BYPASS=0, ZERO_REG=0) instances
    logic [9:0]  rd_addr = '0;
    logic        wr_en   = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        clr_req = 1'b0;
    logic [63:0] rd_data;
    logic [63:0] rd_data_alt;
    logic        busy;
    logic        busy_alt;

    // sweep instance: NRD=3, DEPTH=24, WIDTH=16
    logic [14:0] rd_addr_sw = '0;
    logic        wr_en_sw   = 1'b0;
    logic [4:0]  wr_addr_sw = '0;
    logic [15:0] wr_data_sw = '0;
    logic        clr_req_sw = 1'b0;
    logic [47:0] rd_data_sw;
    logic        busy_sw;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_bank_multiport u_dut (
        .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_data),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .clr_req (clr_req), .clr_busy (busy)
    );

    reg_bank_multiport #(.BYPASS(0), .ZERO_REG(0)) u_alt (
        .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_data_alt),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .clr_req (clr_req), .clr_busy (busy_alt)
    );

    reg_bank_multiport #(.WIDTH(16), .DEPTH(24), .NRD(3)) u_sw (
        .clk (clk), .rst (rst), .rd_addr (rd_addr_sw), .rd_data (rd_data_sw),
        .wr_en (wr_en_sw), .wr_addr (wr_addr_sw), .wr_data (wr_data_sw),
        .clr_req (clr_req_sw), .clr_busy (busy_sw)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops on the main and sweep instances; 0 means it never did.
    task automatic count_clear(output int n_main, output int n_sweep);
        n_main  = 0;
        n_sweep = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (n_main == 0 && !busy) n_main = k;
            if (n_sweep == 0 && !busy_sw) n_sweep = k;
            if (n_main != 0 && n_sweep != 0) break;
        end
    endtask

    initial begin
        int n_main;
        int n_sweep;
        int n_mid;
        bit done;

        // reset and initial clear
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_rd", rd_data, 64'd0);
        rst = 1'b0;
        count_clear(n_main, n_sweep);
        check("rst_clear_edges", 64'(n_main), 64'd32);
        check("rst_clear_edges_sw", 64'(n_sweep), 64'd24);
        check("rst_alt_idle", 64'(busy_alt), 64'd0);

        rd_addr = {5'd5, 5'd5};
        tick();
        check("rd5_after_clear", rd_data, 64'd0);
        rd_addr = {5'd31, 5'd31};
        tick();
        check("rd31_after_clear", rd_data, 64'd0);

        // write-first vs read-old
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd7};
        tick();
        check("byp1_same_edge", 64'(rd_data[31:0]), 64'hDEADBEEF);
        check("byp0_same_edge", 64'(rd_data_alt[31:0]), 64'd0);
        wr_en = 1'b0;
        tick();
        check("byp1_next_edge", 64'(rd_data[31:0]), 64'hDEADBEEF);
        check("byp0_next_edge", 64'(rd_data_alt[31:0]), 64'hDEADBEEF);

        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0BADF00D; rd_addr = {5'd9, 5'd9};
        tick();
        check("byp1_both_ports", rd_data, {32'h0BADF00D, 32'h0BADF00D});
        wr_en = 1'b0;

        // register 0
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; rd_addr = {5'd0, 5'd0};
        tick();
        wr_en = 1'b0;
        tick();
        check("zero_reg_read", rd_data, 64'd0);
        check("no_zero_reg_read", rd_data_alt, {32'h12345678, 32'h12345678});

        // fill, then clear while in use
        for (int a = 1; a < 32; a++) begin
            wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'(a);
            tick();
        end
        wr_en = 1'b0; rd_addr = {5'd31, 5'd5};
        tick();
        check("fill_rd", rd_data, {32'd31, 32'd5});

        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAA; rd_addr = {5'd3, 5'd3};
        tick();
        check("clr_accept_busy", 64'(busy), 64'd1);
        check("clr_accept_rd", rd_data, {32'hAA, 32'hAA});
        clr_req = 1'b0; wr_addr = 5'd4; wr_data = 32'h55; rd_addr = {5'd4, 5'd4};
        n_mid = 0;
        done  = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            clr_req = (k == 5);
            tick();
            n_mid++;
            if (n_mid == 1) check("clr_rd_zero", rd_data, 64'd0);
            if (!busy) done = 1'b1;
        end
        clr_req = 1'b0; wr_en = 1'b0;
        check("clr_mid_edges", 64'(done ? n_mid : 0), 64'd32);
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            tick();
            check("clr_all_zero", rd_data, 64'd0);
            check("clr_all_zero_alt", rd_data_alt, 64'd0);
        end

        // reset mid-clear
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        count_clear(n_main, n_sweep);
        check("rst_mid_edges", 64'(n_main), 64'd32);
        check("rst_mid_edges_sw", 64'(n_sweep), 64'd24);

        // sweep instance
        wr_en_sw = 1'b1; wr_addr_sw = 5'd23; wr_data_sw = 16'hBEEF;
        tick();
        wr_addr_sw = 5'd25; wr_data_sw = 16'h1234; rd_addr_sw = {5'd25, 5'd25, 5'd25};
        tick();
        check("sw_oob_bypass", 64'(rd_data_sw), 64'd0);
        wr_addr_sw = 5'd0; wr_data_sw = 16'h7777; rd_addr_sw = {5'd25, 5'd23, 5'd0};
        tick();
        check("sw_rd_p0", 64'(rd_data_sw[15:0]), 64'd0);
        check("sw_rd_p1", 64'(rd_data_sw[31:16]), 64'hBEEF);
        check("sw_rd_p2", 64'(rd_data_sw[47:32]), 64'd0);
        wr_en_sw = 1'b0; rd_addr_sw = {5'd23, 5'd1, 5'd1};
        tick();
        check("sw_no_alias", 64'(rd_data_sw[31:0]), 64'd0);
        check("sw_hold", 64'(rd_data_sw[47:32]), 64'hBEEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_bank_multiport.md
# reg_bank_multiport

Parametrised general-purpose register bank for the single-cycle processor datapath, replacing the fixed two-read, 32x32 bank. It provides `NRD` registered read ports, one write port with selectable write-to-read bypass, an optional hardwired-zero register 0, and a hardware clear sequencer. The clear sequencer zeroes the array one entry per cycle after reset or on request. It sits between instruction decode (addresses) and the ALU and writeback mux (data).

## Interface
Parameters:
- `WIDTH`, 32: data width in bits.
- `DEPTH`, 32: number of registers, ≥2.
- `NRD`, 2: number of read ports, ≥1.
- `BYPASS`, 1: 1 = write-first (a read returns data written in the same cycle); 0 = read-old.
- `ZERO_REG`, 1: 1 = register 0 always reads 0 and ignores writes.
- `AW`, derived as clog2(`DEPTH`), not user-set.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous and active-high.
- `rd_addr` in `NRD*AW`: read addresses; port i uses bits [i*AW +: AW].
- `rd_data` out `NRD*WIDTH`: registered read data; port i uses bits [i*WIDTH +: WIDTH].
- `wr_en` in 1: write enable.
- `wr_addr` in `AW`: write address.
- `wr_data` in `WIDTH`: write data.
- `clr_req` in 1: single-cycle clear request.
- `clr_busy` out 1: clear sequence in progress; the bank is unusable while high.

## Operation
- FSM states: `CLEAR` and `IDLE`. A 0..`DEPTH`-1 clear counter `cnt` runs alongside.
- Reset (async):
  - state = `CLEAR`, `cnt` = 0, `clr_busy` = 1, all `rd_data` = 0.
  - Array contents are not reset directly; the clear sequence zeroes them.
- `CLEAR` state, each rising edge:
  - reg[`cnt`] <= 0 and `cnt` <= `cnt`+1.
  - When `cnt` == `DEPTH`-1: go to `IDLE` and set `clr_busy` <= 0.
  - Port writes (`wr_en`) are dropped.
  - All `rd_data` <= 0.
  - `clr_req` is ignored; the sequence does not restart.
- `IDLE` state, each rising edge:
  - Write: if `wr_en`, `wr_addr` < `DEPTH`, and not (`ZERO_REG` and `wr_addr` == 0), then reg[`wr_addr`] <= `wr_data`.
  - Read, per port i: `rd_data`[i] <= reg[`rd_addr`[i]].
    - Returns 0 if `rd_addr`[i] ≥ `DEPTH`, or if `ZERO_REG` and `rd_addr`[i] == 0.
    - If `BYPASS` = 1 and a write to the same address is performed this edge, returns `wr_data` instead.
    - With `BYPASS` = 0, returns the pre-write value.
  - If `clr_req`: state <= `CLEAR`, `cnt` <= 0, `clr_busy` <= 1. The write and reads of that same cycle still complete as normal `IDLE` operations.
- All read ports are independent. Any number of ports may read the same address, including the write address.
- `rd_data` holds its last value whenever no new edge arrives; there is no read enable.
- `rst` asserted mid-clear restarts the sequence from `cnt` = 0.

## Timing
- Read latency is 1 cycle: an address presented before edge N produces data valid after edge N.
- Write-to-read: a read address presented in the same cycle as the write sees the new data after the same edge if `BYPASS` = 1, and one cycle later if `BYPASS` = 0.
- Clear duration is exactly `DEPTH` rising edges, after the reset release or after the edge that accepts `clr_req`.
  - With `DEPTH` = 32: after `rst` falls, `clr_busy` drops on the 32nd rising edge.
  - The first write is accepted on the 33rd edge.
- `clr_busy` is a registered output; it is never combinationally derived from `clr_req`.

## Structure
- Shared package `reg_bank_pkg` holds:
  - the state enum (`IDLE`, `CLEAR`);
  - a clog2 function used to derive `AW`.
- Sub-module `reg_bank_clear_ctrl` contains the FSM and `cnt`. It outputs `clr_busy`, the clear write strobe and the clear address. The top level muxes these against the port write and holds the array plus the read logic.

## Test plan
- Reset and clear:
  - Assert `rst`, release it, and count edges: `clr_busy` stays high exactly 32 edges.
  - Then reading addresses 5 and 31 returns 0x00000000 on both ports.
- Write/read with `BYPASS` = 1:
  - Write 0xDEADBEEF to reg 7 while port 0 reads 7: `rd_data`[0] = 0xDEADBEEF after the same edge.
  - Repeat with `BYPASS` = 0: the first edge returns 0, the next returns 0xDEADBEEF.
- Register 0:
  - Write 0x12345678 to reg 0, then read it on both ports: both return 0.
  - With `ZERO_REG` = 0, the same sequence returns 0x12345678.
- Clear mid-use:
  - Fill regs 1..31 with their index.
  - Pulse `clr_req` together with a write of 0xAA to reg 3.
  - `clr_busy` goes high for 32 edges; writes during that window are dropped.
  - Afterwards all registers read 0.
  - A second `clr_req` sent during the clear does not extend `clr_busy`.
- Reset mid-clear:
  - Assert `rst` at `cnt` = 10.
  - `clr_busy` stays high and the full 32 edges are counted again after release.
- Parameter sweep with `NRD` = 3, `DEPTH` = 24, `WIDTH` = 16:
  - Simultaneous reads of 0, 23 and 25 return 0, the stored value, and 0.
  - A write to address 25 is ignored.
